// File: rtl/operand_sequencer.sv
// operand_sequencer
//   Front end for the arithmetic unit. It conditions two raw push buttons
//   (ENTER, CLEAR) and uses debounced ENTER presses to capture operand A, then
//   operand B together with the op select, from the board switches. The result
//   is presented as a packed operand word {A,B} plus a mode.
//
//   Ports
//     clk        in   1  system clock, rising edge
//     rst_n      in   1  asynchronous active-low reset
//     sw_data    in   4  operand nibble from switches
//     sw_mode    in   2  op select (00 add, 01 sub, 10 x2, 11 /2)
//     btn_enter  in   1  raw ENTER button, active-high, bouncy
//     btn_clear  in   1  raw CLEAR button, active-high, bouncy
//     i_out      out  8  {A,B}, A in [7:4], B in [3:0]
//     mode_out   out  2  registered op select
//     valid      out  1  high while in S_DONE
//     go         out  1  one-cycle strobe when mode_out is loaded
//     state_dbg  out  2  current state encoding
module operand_sequencer #(
   parameter int DB_CYCLES = 16,
   parameter int DB_W      = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw_data,
   input  logic [1:0] sw_mode,
   input  logic       btn_enter,
   input  logic       btn_clear,
   output logic [7:0] i_out,
   output logic [1:0] mode_out,
   output logic       valid,
   output logic       go,
   output logic [1:0] state_dbg
);

   localparam logic [1:0] S_A    = 2'b00;
   localparam logic [1:0] S_B    = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   localparam logic [DB_W-1:0] CNT_MAX  = DB_W'(DB_CYCLES - 1);
   localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);
   localparam logic [DB_W-1:0] CNT_ZERO = DB_W'(0);

   // Bit 0 is ENTER, bit 1 is CLEAR throughout the conditioning path.
   logic [1:0]      w_btn_raw;
   logic [1:0]      r_sync1;
   logic [1:0]      r_sync2;
   logic [1:0]      r_db;
   logic [1:0]      r_db_q;
   logic [DB_W-1:0] r_cnt [2];
   logic [1:0]      w_ev;
   logic            w_enter_ev;
   logic            w_clear_ev;

   logic [1:0]      r_state;
   logic [7:0]      r_i_out;
   logic [1:0]      r_mode;
   logic            r_go;
   logic            r_valid;

   logic [1:0]      w_state_nx;
   logic [7:0]      w_i_out_nx;
   logic [1:0]      w_mode_nx;
   logic            w_go_nx;

   assign w_btn_raw  = {btn_clear, btn_enter};
   // Rising edge of the debounced level: one cycle per accepted press.
   assign w_ev       = r_db & ~r_db_q;
   assign w_enter_ev = w_ev[0];
   assign w_clear_ev = w_ev[1];

   // Synchronise and debounce both buttons; the level only moves after the
   // synced input has disagreed with it for DB_CYCLES consecutive cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 2'b00;
         r_sync2 <= 2'b00;
         r_db    <= 2'b00;
         r_db_q  <= 2'b00;
         for (int k = 0; k < 2; k++) begin
            r_cnt[k] <= CNT_ZERO;
         end
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
         r_db_q  <= r_db;
         for (int k = 0; k < 2; k++) begin
            if (r_sync2[k] == r_db[k]) begin
               r_cnt[k] <= CNT_ZERO;
            end else if (r_cnt[k] == CNT_MAX) begin
               r_db[k]  <= r_sync2[k];
               r_cnt[k] <= CNT_ZERO;
            end else begin
               r_cnt[k] <= r_cnt[k] + CNT_ONE;
            end
         end
      end
   end

   // Next-state and output decode; clear overrides any simultaneous enter.
   always_comb begin
      w_state_nx = r_state;
      w_i_out_nx = r_i_out;
      w_mode_nx  = r_mode;
      w_go_nx    = 1'b0;
      if (w_clear_ev) begin
         w_state_nx = S_A;
         w_i_out_nx = 8'h00;
         w_mode_nx  = 2'b00;
      end else begin
         case (r_state)
            S_A: begin
               if (w_enter_ev) begin
                  w_i_out_nx = {sw_data, r_i_out[3:0]};
                  w_state_nx = S_B;
               end else begin
                  w_state_nx = S_A;
               end
            end
            S_B: begin
               if (w_enter_ev) begin
                  w_i_out_nx = {r_i_out[7:4], sw_data};
                  w_mode_nx  = sw_mode;
                  w_go_nx    = 1'b1;
                  w_state_nx = S_DONE;
               end else begin
                  w_state_nx = S_B;
               end
            end
            S_DONE: begin
               // Re-run the held operands with a new op select.
               if (w_enter_ev) begin
                  w_mode_nx = sw_mode;
                  w_go_nx   = 1'b1;
               end else begin
                  w_mode_nx = r_mode;
               end
            end
            default: begin
               w_state_nx = S_A;
               w_i_out_nx = 8'h00;
               w_mode_nx  = 2'b00;
            end
         endcase
      end
   end

   // Register state and all outputs so nothing downstream sees decode glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_A;
         r_i_out <= 8'h00;
         r_mode  <= 2'b00;
         r_go    <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_i_out <= w_i_out_nx;
         r_mode  <= w_mode_nx;
         r_go    <= w_go_nx;
         r_valid <= (w_state_nx == S_DONE);
      end
   end

   assign i_out     = r_i_out;
   assign mode_out  = r_mode;
   assign valid     = r_valid;
   assign go        = r_go;
   assign state_dbg = r_state;

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;

   logic       clk;
   logic       rst_n;
   logic [3:0] sw_data;
   logic [1:0] sw_mode;
   logic       btn_enter;
   logic       btn_clear;
   logic [7:0] i_out;
   logic [1:0] mode_out;
   logic       valid;
   logic       go;
   logic [1:0] state_dbg;

   int checks;
   int errors;
   int go_count;
   int go_base;

   operand_sequencer #(.DB_CYCLES(4), .DB_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw_data   (sw_data),
      .sw_mode   (sw_mode),
      .btn_enter (btn_enter),
      .btn_clear (btn_clear),
      .i_out     (i_out),
      .mode_out  (mode_out),
      .valid     (valid),
      .go        (go),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count go pulses, sampled away from the active edge.
   always @(negedge clk) begin
      if (go === 1'b1) go_count <= go_count + 1;
   end

   // Raise buttons at a negedge, return at the negedge after edge 6 of the press.
   task automatic start_press(input logic [3:0] d, input logic [1:0] m,
                              input logic en, input logic clr);
      @(negedge clk);
      sw_data   = d;
      sw_mode   = m;
      btn_enter = en;
      btn_clear = clr;
      repeat (6) @(negedge clk);
   endtask

   task automatic release_btns();
      btn_enter = 1'b0;
      btn_clear = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      #22;
      checks++;
      if (i_out !== 8'h00 || mode_out !== 2'b00 || state_dbg !== 2'b00 ||
          valid !== 1'b0 || go !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got i_out=%h mode=%b st=%b valid=%b go=%b want 00 00 00 0 0",
                  i_out, mode_out, state_dbg, valid, go);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (state_dbg !== 2'b00 || go_count !== 0) begin
         errors++;
         $display("FAIL reset_idle got st=%b gos=%0d want 00 0", state_dbg, go_count);
      end
   endtask

   task automatic test_load();
      go_base = go_count;
      start_press(4'h9, 2'b10, 1'b1, 1'b0);
      checks++;
      if (state_dbg !== 2'b00 || i_out !== 8'h00) begin
         errors++;
         $display("FAIL load_a_early got st=%b i_out=%h want 00 00", state_dbg, i_out);
      end
      @(negedge clk);
      checks++;
      if (state_dbg !== 2'b01 || i_out !== 8'h90 || go !== 1'b0 || valid !== 1'b0) begin
         errors++;
         $display("FAIL load_a got st=%b i_out=%h go=%b valid=%b want 01 90 0 0",
                  state_dbg, i_out, go, valid);
      end
      release_btns();
      start_press(4'h3, 2'b00, 1'b1, 1'b0);
      checks++;
      if (go !== 1'b0 || state_dbg !== 2'b01) begin
         errors++;
         $display("FAIL load_b_early got go=%b st=%b want 0 01", go, state_dbg);
      end
      @(negedge clk);
      checks++;
      if (i_out !== 8'h93 || mode_out !== 2'b00 || valid !== 1'b1 ||
          go !== 1'b1 || state_dbg !== 2'b10) begin
         errors++;
         $display("FAIL load_b got i_out=%h mode=%b valid=%b go=%b st=%b want 93 00 1 1 10",
                  i_out, mode_out, valid, go, state_dbg);
      end
      @(negedge clk);
      checks++;
      if (go !== 1'b0) begin
         errors++;
         $display("FAIL go_one_cycle got go=%b want 0", go);
      end
      release_btns();
      checks++;
      if (go_count - go_base !== 1 || i_out !== 8'h93 || valid !== 1'b1) begin
         errors++;
         $display("FAIL load_release got gos=%0d i_out=%h valid=%b want 1 93 1",
                  go_count - go_base, i_out, valid);
      end
   endtask

   task automatic test_rerun();
      go_base = go_count;
      start_press(4'hF, 2'b11, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (mode_out !== 2'b11 || i_out !== 8'h93 || go !== 1'b1 || state_dbg !== 2'b10) begin
         errors++;
         $display("FAIL rerun got mode=%b i_out=%h go=%b st=%b want 11 93 1 10",
                  mode_out, i_out, go, state_dbg);
      end
      release_btns();
      checks++;
      if (go_count - go_base !== 1 || valid !== 1'b1) begin
         errors++;
         $display("FAIL rerun_once got gos=%0d valid=%b want 1 1", go_count - go_base, valid);
      end
   endtask

   task automatic test_bounce();
      go_base = go_count;
      @(negedge clk);
      sw_mode   = 2'b01;
      btn_enter = 1'b1;
      repeat (3) @(negedge clk);
      btn_enter = 1'b0;
      @(negedge clk);
      btn_enter = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (go_count - go_base !== 0 || mode_out !== 2'b11) begin
         errors++;
         $display("FAIL bounce_early got gos=%0d mode=%b want 0 11", go_count - go_base, mode_out);
      end
      @(negedge clk);
      checks++;
      if (go !== 1'b1 || mode_out !== 2'b01) begin
         errors++;
         $display("FAIL bounce_event got go=%b mode=%b want 1 01", go, mode_out);
      end
      repeat (3) @(negedge clk);
      release_btns();
      checks++;
      if (go_count - go_base !== 1) begin
         errors++;
         $display("FAIL bounce_count got %0d want 1", go_count - go_base);
      end
      go_base = go_count;
      sw_mode   = 2'b10;
      btn_enter = 1'b1;
      repeat (3) @(negedge clk);
      release_btns();
      checks++;
      if (go_count - go_base !== 0 || mode_out !== 2'b01) begin
         errors++;
         $display("FAIL short_pulse got gos=%0d mode=%b want 0 01", go_count - go_base, mode_out);
      end
   endtask

   task automatic test_clear_enter();
      start_press(4'h0, 2'b00, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (state_dbg !== 2'b00 || i_out !== 8'h00 || mode_out !== 2'b00 || valid !== 1'b0) begin
         errors++;
         $display("FAIL clear got st=%b i_out=%h mode=%b valid=%b want 00 00 00 0",
                  state_dbg, i_out, mode_out, valid);
      end
      release_btns();
      start_press(4'h5, 2'b00, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (state_dbg !== 2'b01 || i_out !== 8'h50) begin
         errors++;
         $display("FAIL reload_a got st=%b i_out=%h want 01 50", state_dbg, i_out);
      end
      release_btns();
      go_base = go_count;
      start_press(4'h7, 2'b10, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if (state_dbg !== 2'b00 || i_out !== 8'h00 || go !== 1'b0 || mode_out !== 2'b00) begin
         errors++;
         $display("FAIL clear_wins got st=%b i_out=%h go=%b mode=%b want 00 00 0 00",
                  state_dbg, i_out, go, mode_out);
      end
      release_btns();
      checks++;
      if (go_count - go_base !== 0 || state_dbg !== 2'b00) begin
         errors++;
         $display("FAIL clear_wins_after got gos=%0d st=%b want 0 00", go_count - go_base, state_dbg);
      end
   endtask

   task automatic test_hold();
      go_base = go_count;
      start_press(4'hA, 2'b00, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (state_dbg !== 2'b01 || i_out !== 8'hA0) begin
         errors++;
         $display("FAIL hold_first got st=%b i_out=%h want 01 a0", state_dbg, i_out);
      end
      repeat (43) @(negedge clk);
      checks++;
      if (state_dbg !== 2'b01 || i_out !== 8'hA0) begin
         errors++;
         $display("FAIL hold_held got st=%b i_out=%h want 01 a0", state_dbg, i_out);
      end
      release_btns();
      checks++;
      if (state_dbg !== 2'b01 || i_out !== 8'hA0 || go_count - go_base !== 0) begin
         errors++;
         $display("FAIL hold_release got st=%b i_out=%h gos=%0d want 01 a0 0",
                  state_dbg, i_out, go_count - go_base);
      end
   endtask

   task automatic test_reset_mid();
      start_press(4'h0, 2'b00, 1'b0, 1'b1);
      release_btns();
      start_press(4'h9, 2'b00, 1'b1, 1'b0);
      @(negedge clk);
      release_btns();
      checks++;
      if (state_dbg !== 2'b01 || i_out !== 8'h90) begin
         errors++;
         $display("FAIL mid_setup got st=%b i_out=%h want 01 90", state_dbg, i_out);
      end
      go_base = go_count;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (i_out !== 8'h00 || state_dbg !== 2'b00 || valid !== 1'b0 || go !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got i_out=%h st=%b valid=%b go=%b want 00 00 0 0",
                  i_out, state_dbg, valid, go);
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (state_dbg !== 2'b00 || i_out !== 8'h00 || go_count - go_base !== 0) begin
         errors++;
         $display("FAIL mid_after got st=%b i_out=%h gos=%0d want 00 00 0",
                  state_dbg, i_out, go_count - go_base);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      go_count  = 0;
      go_base   = 0;
      rst_n     = 1'b0;
      sw_data   = 4'h0;
      sw_mode   = 2'b00;
      btn_enter = 1'b0;
      btn_clear = 1'b0;
      test_reset();
      test_load();
      test_rerun();
      test_bounce();
      test_clear_enter();
      test_hold();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
